rdma_ctrl_rr_arbiter: RTL and testbench
=======================================

Name: rdma_ctrl_rr_arbiter

Overview:
- Merges RDMA control requests from N_REGIONS user regions (vFPGAs) into the single user-side QP and connection request streams.
- Those streams then enter the RDMA control register-slice chain towards the network stack.
- Two independent round-robin arbiters: QP and CONN.
- Each arbiter has a registered single-beat output and reports which region won each beat.

Parameters:
- N_REGIONS, 4, number of user regions; legal range 1..16.
- QP_BITS, 184, width of one QP request beat (RDMA_QP_INTF_BITS).
- CONN_BITS, 184, width of one connection request beat (RDMA_QP_CONN_BITS).
- ID_BITS, 4, width of region-id tags; must satisfy 2^ID_BITS >= N_REGIONS.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_qp_valid  in  N_REGIONS  per-region QP request valid
- s_qp_ready  out  N_REGIONS  per-region QP request ready
- s_qp_data  in  N_REGIONS*QP_BITS  QP payloads; region i occupies slice [i*QP_BITS +: QP_BITS]
- s_conn_valid  in  N_REGIONS  per-region CONN valid
- s_conn_ready  out  N_REGIONS  per-region CONN ready
- s_conn_data  in  N_REGIONS*CONN_BITS  CONN payloads, sliced the same way
- m_qp_valid  out  1  merged QP valid
- m_qp_ready  in  1  merged QP ready
- m_qp_data  out  QP_BITS  merged QP payload
- m_qp_id  out  ID_BITS  source region of the current m_qp beat
- m_conn_valid  out  1  merged CONN valid
- m_conn_ready  in  1  merged CONN ready
- m_conn_data  out  CONN_BITS  merged CONN payload
- m_conn_id  out  ID_BITS  source region of the current m_conn beat

Behaviour:
- Clock and reset: one clock domain, aclk; areset asynchronous, active-high; reset is released synchronously by the integrating logic.
- Reset values: m_*_valid=0, m_*_data=0, m_*_id=0, round-robin pointers=0 (region 0 has highest priority).
- While areset is high, s_*_ready=0.
- QP and CONN paths are identical and fully independent. Rules below are written for one path.
- Output register free: free = !m_valid || m_ready (combinational).
- Grant selection:
  - Scan s_valid starting at index ptr, ascending, wrapping modulo N_REGIONS.
  - The first asserted index is the winner g.
  - If no s_valid is asserted, there is no grant.
- s_ready[g] = free && any s_valid. All other s_ready bits = 0.
  - s_ready depends combinationally on s_valid and m_ready; this is intentional.
  - The path must not create a combinational loop with a registered upstream.
- On transfer (s_valid[g] && s_ready[g]) at edge k:
  - m_data <= s_data[g], m_id <= g, m_valid <= 1 at edge k.
  - Latency is exactly 1 cycle.
  - ptr <= (g+1) mod N_REGIONS.
- If m_valid && m_ready with no new transfer: m_valid <= 0; data and id hold their last values.
- Simultaneous drain and load: back-to-back beats with no bubble; sustained throughput is 1 beat/cycle.
- Stall: while m_valid && !m_ready, m_data and m_id must stay stable, all s_ready=0, and ptr holds.
- ptr advances only on a completed transfer. An idle cycle, or a deasserted valid, never moves it.
- Fairness: with all regions continuously requesting, the grant order is ptr, ptr+1, ..., wrapping. No region waits more than N_REGIONS-1 grants.
- A source that deasserts valid before being granted simply loses its turn. The arbiter keeps no memory of it.
- N_REGIONS=1: degenerates to a single register slice; ptr is constant 0; m_id=0.
- Reset mid-operation: any beat held in the output register is dropped (m_valid -> 0 asynchronously) and ptr returns to 0. Upstream sources retain their beats, because ready was low.
- Ready never depends on data content. No payload bits are modified.

Test Plan:
1. Single region 2 sends one QP beat 0xABC with m_qp_ready=1 -> m_qp_valid rises the next cycle with data 0xABC, m_qp_id=2; ptr becomes 3.
2. All 4 regions hold valid continuously, m_qp_ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles with no gaps; each s_qp_ready is one-hot per cycle.
3. Backpressure: m_qp_ready=0 for 5 cycles with a beat held -> m_qp_data and m_qp_id stable and all s_qp_ready=0 for those 5 cycles. Raise ready -> a new beat is loaded the same cycle and the next id follows round-robin.
4. Independence: CONN traffic from region 1 while the QP path is stalled -> CONN beats flow at 1/cycle with m_conn_id=1; QP outputs unchanged.
5. Valid withdrawal: region 1 valid for 1 cycle while region 0 is granted, then region 3 requests -> grant order is 0 then 3, and ptr=0 after the second grant.
6. Assert areset while m_qp_valid=1 and stalled -> m_qp_valid=0 immediately, ptr=0. After release with all regions valid, the first grant goes to region 0.

Source files
------------

// File: rtl/rdma_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rdma_ctrl_rr_arbiter (with helper rdma_ctrl_rr_path)
// Brief    : Merges per-region RDMA QP and CONN request streams through two
//            independent round-robin arbiters with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================

module rdma_ctrl_rr_path #(
    parameter int N_REGIONS = 4,
    parameter int W         = 184,
    parameter int ID_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REGIONS-1:0]   i_valid,
    output logic [N_REGIONS-1:0]   o_ready,
    input  logic [N_REGIONS*W-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [W-1:0]           o_data,
    output logic [ID_BITS-1:0]     o_id
);

    logic               r_valid;
    logic [W-1:0]       r_data;
    logic [ID_BITS-1:0] r_id;
    logic [ID_BITS-1:0] r_ptr;

    logic               w_free;
    logic               w_found;
    logic               w_xfer;
    logic [ID_BITS-1:0] w_gnt;
    logic [ID_BITS-1:0] w_ptr_nxt;
    logic [W-1:0]       w_sel_data;
    int                 w_idx;

    assign w_free = !r_valid || i_ready;

    // First requester at or after r_ptr, wrapping modulo N_REGIONS
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REGIONS; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REGIONS;
            if (!w_found && i_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_BITS'(w_idx);
            end
        end
    end

    assign w_xfer    = w_free && w_found && !rst;
    assign w_ptr_nxt = (w_gnt == ID_BITS'(N_REGIONS - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        o_ready    = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (w_gnt == ID_BITS'(i)) begin
                o_ready[i] = w_xfer;
                w_sel_data = i_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_id    <= w_gnt;
            r_ptr   <= w_ptr_nxt;
        end else if (i_ready) begin
            // Drained with nothing to replace it; payload and id hold
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_id    = r_id;

endmodule

module rdma_ctrl_rr_arbiter #(
    parameter int N_REGIONS = 4,
    parameter int QP_BITS   = 184,
    parameter int CONN_BITS = 184,
    parameter int ID_BITS   = 4
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [N_REGIONS-1:0]           s_qp_valid,
    output logic [N_REGIONS-1:0]           s_qp_ready,
    input  logic [N_REGIONS*QP_BITS-1:0]   s_qp_data,
    input  logic [N_REGIONS-1:0]           s_conn_valid,
    output logic [N_REGIONS-1:0]           s_conn_ready,
    input  logic [N_REGIONS*CONN_BITS-1:0] s_conn_data,
    output logic                           m_qp_valid,
    input  logic                           m_qp_ready,
    output logic [QP_BITS-1:0]             m_qp_data,
    output logic [ID_BITS-1:0]             m_qp_id,
    output logic                           m_conn_valid,
    input  logic                           m_conn_ready,
    output logic [CONN_BITS-1:0]           m_conn_data,
    output logic [ID_BITS-1:0]             m_conn_id
);

    rdma_ctrl_rr_path #(
        .N_REGIONS (N_REGIONS),
        .W         (QP_BITS),
        .ID_BITS   (ID_BITS)
    ) u_qp (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (s_qp_valid),
        .o_ready (s_qp_ready),
        .i_data  (s_qp_data),
        .o_valid (m_qp_valid),
        .i_ready (m_qp_ready),
        .o_data  (m_qp_data),
        .o_id    (m_qp_id)
    );

    rdma_ctrl_rr_path #(
        .N_REGIONS (N_REGIONS),
        .W         (CONN_BITS),
        .ID_BITS   (ID_BITS)
    ) u_conn (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (s_conn_valid),
        .o_ready (s_conn_ready),
        .i_data  (s_conn_data),
        .o_valid (m_conn_valid),
        .i_ready (m_conn_ready),
        .o_data  (m_conn_data),
        .o_id    (m_conn_id)
    );

endmodule

`default_nettype wire

// File: tb/tb_rdma_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdma_ctrl_rr_arbiter
// Brief    : Directed self-checking bench for the QP/CONN round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rdma_ctrl_rr_arbiter;

    localparam int N  = 4;
    localparam int QB = 184;
    localparam int CB = 184;
    localparam int IB = 4;

    logic            aclk;
    logic            areset;
    logic [N-1:0]    s_qp_valid;
    logic [N-1:0]    s_qp_ready;
    logic [N*QB-1:0] s_qp_data;
    logic [N-1:0]    s_conn_valid;
    logic [N-1:0]    s_conn_ready;
    logic [N*CB-1:0] s_conn_data;
    logic            m_qp_valid;
    logic            m_qp_ready;
    logic [QB-1:0]   m_qp_data;
    logic [IB-1:0]   m_qp_id;
    logic            m_conn_valid;
    logic            m_conn_ready;
    logic [CB-1:0]   m_conn_data;
    logic [IB-1:0]   m_conn_id;

    int n_cmp = 0;
    int n_err = 0;

    rdma_ctrl_rr_arbiter #(
        .N_REGIONS (N),
        .QP_BITS   (QB),
        .CONN_BITS (CB),
        .ID_BITS   (IB)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_qp_valid   (s_qp_valid),
        .s_qp_ready   (s_qp_ready),
        .s_qp_data    (s_qp_data),
        .s_conn_valid (s_conn_valid),
        .s_conn_ready (s_conn_ready),
        .s_conn_data  (s_conn_data),
        .m_qp_valid   (m_qp_valid),
        .m_qp_ready   (m_qp_ready),
        .m_qp_data    (m_qp_data),
        .m_qp_id      (m_qp_id),
        .m_conn_valid (m_conn_valid),
        .m_conn_ready (m_conn_ready),
        .m_conn_data  (m_conn_data),
        .m_conn_id    (m_conn_id)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [QB-1:0] obs, input logic [QB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Checks the QP beat registered at the edge just taken
    task automatic chk_qp_beat(input string tag, input int id, input logic [QB-1:0] data);
        chk({tag, "_valid"}, QB'(m_qp_valid), QB'(1));
        chk({tag, "_id"},    QB'(m_qp_id),    QB'(id));
        chk({tag, "_data"},  m_qp_data,       data);
    endtask

    initial begin
        areset       = 1'b1;
        s_qp_valid   = 4'hF;
        s_conn_valid = 4'hF;
        m_qp_ready   = 1'b1;
        m_conn_ready = 1'b1;
        s_qp_data    = '0;
        s_conn_data  = '0;
        repeat (3) step();

        // Reset state
        chk("rst_qp_valid",   QB'(m_qp_valid),   QB'(0));
        chk("rst_qp_data",    m_qp_data,         QB'(0));
        chk("rst_qp_id",      QB'(m_qp_id),      QB'(0));
        chk("rst_conn_valid", QB'(m_conn_valid), QB'(0));
        chk("rst_qp_ready",   QB'(s_qp_ready),   QB'(0));
        chk("rst_conn_ready", QB'(s_conn_ready), QB'(0));

        s_qp_valid   = '0;
        s_conn_valid = '0;
        areset       = 1'b0;
        step();

        // Test 1: single beat from region 2
        s_qp_data[2*QB +: QB] = QB'(12'hABC);
        s_qp_valid = 4'b0100;
        #1;
        chk("t1_s_ready", QB'(s_qp_ready), QB'(4'b0100));
        step();
        s_qp_valid = '0;
        chk_qp_beat("t1", 2, QB'(12'hABC));
        step();
        chk("t1_drain", QB'(m_qp_valid), QB'(0));

        // Test 2: all regions requesting; pointer is now 3
        for (int i = 0; i < N; i++) s_qp_data[i*QB +: QB] = QB'(256 + i);
        s_qp_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            int e;
            e = (3 + k) % N;
            #1;
            chk("t2_s_ready", QB'(s_qp_ready), QB'(1 << e));
            step();
            chk_qp_beat("t2", e, QB'(256 + e));
        end

        // Test 3: stall with region 0's beat held; pointer is 1
        m_qp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_stall_ready", QB'(s_qp_ready), QB'(0));
            step();
            chk_qp_beat("t3_stall", 0, QB'(256));
        end
        m_qp_ready = 1'b1;
        #1;
        chk("t3_resume_ready", QB'(s_qp_ready), QB'(4'b0010));
        step();
        chk_qp_beat("t3_resume", 1, QB'(257));

        // Test 4: CONN flows from region 1 while QP is stalled
        m_qp_ready   = 1'b0;
        s_conn_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            s_conn_data[1*CB +: CB] = CB'(32'hC00 + k);
            #1;
            chk("t4_conn_ready", QB'(s_conn_ready), QB'(4'b0010));
            chk("t4_qp_ready",   QB'(s_qp_ready),   QB'(0));
            step();
            chk("t4_conn_valid", QB'(m_conn_valid), QB'(1));
            chk("t4_conn_id",    QB'(m_conn_id),    QB'(1));
            chk("t4_conn_data",  m_conn_data,       QB'(32'hC00 + k));
            chk_qp_beat("t4_qp_hold", 1, QB'(257));
        end
        s_conn_valid = '0;
        s_qp_valid   = '0;
        m_qp_ready   = 1'b1;
        step();
        chk("t4_qp_drain",   QB'(m_qp_valid),   QB'(0));
        chk("t4_conn_drain", QB'(m_conn_valid), QB'(0));

        // Test 5: pointer is 2; region 3 alone brings it back to 0
        s_qp_valid = 4'b1000;
        step();
        chk_qp_beat("t5_pre", 3, QB'(259));
        s_qp_valid = 4'b0011;
        #1;
        chk("t5_a_ready", QB'(s_qp_ready), QB'(4'b0001));
        step();
        chk_qp_beat("t5_a", 0, QB'(256));
        s_qp_valid = 4'b1000;
        #1;
        chk("t5_b_ready", QB'(s_qp_ready), QB'(4'b1000));
        step();
        chk_qp_beat("t5_b", 3, QB'(259));
        s_qp_valid = 4'hF;
        #1;
        chk("t5_c_ready", QB'(s_qp_ready), QB'(4'b0001));
        step();
        chk_qp_beat("t5_c", 0, QB'(256));

        // Test 6: async reset while a beat is stalled (pointer is 1)
        m_qp_ready = 1'b0;
        step();
        chk_qp_beat("t6_stall", 0, QB'(256));
        #2;
        areset = 1'b1;
        #1;
        chk("t6_rst_valid", QB'(m_qp_valid), QB'(0));
        chk("t6_rst_data",  m_qp_data,       QB'(0));
        chk("t6_rst_ready", QB'(s_qp_ready), QB'(0));
        step();
        areset     = 1'b0;
        m_qp_ready = 1'b1;
        #1;
        chk("t6_post_ready", QB'(s_qp_ready), QB'(4'b0001));
        step();
        chk_qp_beat("t6_post", 0, QB'(256));
        s_qp_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
